// File: rtl/da_tap_loader.sv
// da_tap_loader: eight-tap delay line feeding a bit-serial distributed
// arithmetic LUT. Each accepted sample shifts the taps, then the taps are
// held for DATA_W cycles while bit_cnt walks LSB to MSB. bit_slice gathers
// bit bit_cnt of every tap to form the LUT address.
//
// Handshake: sample_in is taken on a rising edge only when sample_valid and
// sample_ready are both high in that cycle (accept). sample_ready is a
// combinational function of reset, clear, state and bit_cnt, never of
// sample_valid. A producer may hold sample_valid high indefinitely; the
// sample stays pending until accept and is consumed exactly once.
module da_tap_loader #(
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [DATA_W-1:0]         sample_in,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic [DATA_W-1:0]         x1_bit,
    output logic [DATA_W-1:0]         x2_bit,
    output logic [DATA_W-1:0]         x3_bit,
    output logic [DATA_W-1:0]         x4_bit,
    output logic [DATA_W-1:0]         x5_bit,
    output logic [DATA_W-1:0]         x6_bit,
    output logic [DATA_W-1:0]         x7_bit,
    output logic [DATA_W-1:0]         x8_bit,
    output logic [7:0]                bit_slice,
    output logic [$clog2(DATA_W)-1:0] bit_cnt,
    output logic                      frame_start,
    output logic                      frame_done,
    output logic                      state_dbg
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam int NUM_TAPS = 8;

    // IDLE: waiting for a sample, taps parked. HOLD: taps frozen while the
    // bit-serial frame runs.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              frame_start_nxt;
    logic              frame_done_nxt;
    logic              last_bit;
    logic              accept;
    logic              shift_taps;
    logic              zero_taps;
    logic [DATA_W-1:0] taps [NUM_TAPS];

    // The final bit of a frame is the only HOLD cycle that can take a new
    // sample, which gives one frame per DATA_W cycles when fully loaded.
    assign last_bit     = (state == HOLD) && (bit_cnt == LAST_BIT);
    assign sample_ready = !reset && !clear && ((state == IDLE) || last_bit);
    assign accept       = sample_valid && sample_ready;

    // Next-state, next-count and tap control; clear outranks accept.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = bit_cnt;
        shift_taps      = 1'b0;
        zero_taps       = 1'b0;
        frame_start_nxt = 1'b0;
        frame_done_nxt  = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            zero_taps = 1'b1;
        end else if (accept) begin
            state_nxt  = HOLD;
            cnt_nxt    = '0;
            shift_taps = 1'b1;
        end else if (state == HOLD) begin
            if (last_bit) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = bit_cnt + CNT_W'(1);
            end
        end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
        // Frame markers are registered so they appear in the cycle whose
        // bit_cnt they describe; an aborted frame never reaches LAST_BIT.
        frame_start_nxt = (state_nxt == HOLD) && (cnt_nxt == '0);
        frame_done_nxt  = (state_nxt == HOLD) && (cnt_nxt == LAST_BIT);
    end

    // State, bit counter and frame marker registers; reset dominates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= cnt_nxt;
            frame_start <= frame_start_nxt;
            frame_done  <= frame_done_nxt;
        end
    end

    // Delay line: flushed by reset or clear, shifted only on accept.
    always_ff @(posedge clk) begin
        if (reset || zero_taps) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                taps[i] <= '0;
            end
        end else if (shift_taps) begin
            for (int i = NUM_TAPS - 1; i > 0; i--) begin
                taps[i] <= taps[i-1];
            end
            taps[0] <= sample_in;
        end
    end

    // LUT address: one bit per tap at the current bit position. In IDLE
    // bit_cnt is 0, so the address shows bit 0 of every tap.
    always_comb begin
        bit_slice = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            bit_slice[i] = taps[i][bit_cnt];
        end
    end

    assign x1_bit    = taps[0];
    assign x2_bit    = taps[1];
    assign x3_bit    = taps[2];
    assign x4_bit    = taps[3];
    assign x5_bit    = taps[4];
    assign x6_bit    = taps[5];
    assign x7_bit    = taps[6];
    assign x8_bit    = taps[7];
    assign state_dbg = (state == HOLD);

endmodule

// File: doc/da_tap_loader.md
DA_TAP_LOADER -- requirements
Module: da_tap_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the sample width and the number of bit-serial cycles per frame.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset that is synchronous and active-high.
REQ-004 The block SHALL have port clear, input, 1 bit: synchronous flush of the delay line.
REQ-005 The block SHALL have port sample_in, input, DATA_W bits: new input sample.
REQ-006 The block SHALL have port sample_valid, input, 1 bit: sample_in is valid.
REQ-007 The block SHALL have port sample_ready, output, 1 bit: the block accepts sample_in this cycle.
REQ-008 The block SHALL have ports x1_bit..x8_bit, output, DATA_W bits each: tap samples; x1_bit is the newest, x8_bit the oldest.
REQ-009 The block SHALL have port bit_slice, output, 8 bits: bit[i-1] = x<i>_bit[bit_cnt], the DA LUT address.
REQ-010 The block SHALL have port bit_cnt, output, clog2(DATA_W) bits: current bit position, LSB first.
REQ-011 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse on the first HOLD cycle of a frame.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse on the last HOLD cycle (bit_cnt = DATA_W-1).

Function
REQ-013 The block SHALL implement states IDLE and HOLD.
REQ-014 The block SHALL drive sample_ready = !reset && !clear && (state==IDLE || (state==HOLD && bit_cnt==DATA_W-1)), combinationally.
REQ-015 The block SHALL define accept as sample_valid && sample_ready; on accept the taps SHALL shift at the clock edge: x8<=x7, ..., x2<=x1, x1<=sample_in.
REQ-016 On accept the block SHALL enter HOLD with bit_cnt=0 and frame_start=1 in the following cycle.
REQ-017 In HOLD the block SHALL increment bit_cnt by 1 per cycle and SHALL keep the taps stable for exactly DATA_W cycles.
REQ-018 In HOLD at bit_cnt==DATA_W-1, the block SHALL assert frame_done; with accept it SHALL re-enter HOLD at bit_cnt=0 (back-to-back, one frame per DATA_W cycles); without accept it SHALL go to IDLE with bit_cnt=0.
REQ-019 In IDLE without accept, the block SHALL hold the taps, keep bit_cnt=0, and drive frame_start=0 and frame_done=0.
REQ-020 The block SHALL ignore sample_valid while sample_ready is 0 and SHALL NOT shift the taps.
REQ-021 The block SHALL drive bit_slice combinationally from the taps and bit_cnt; in IDLE, bit_slice SHALL reflect bit 0 of the taps.
REQ-022 On clear=1, the block SHALL zero all taps, force IDLE, set bit_cnt=0, deassert frame_start and frame_done next cycle, and accept no sample; clear SHALL have priority over accept.
REQ-023 The block SHALL give clear mid-frame the same effect: the frame aborts and no frame_done is issued for it.
REQ-024 Taps SHALL be unsigned bit containers; the block SHALL perform no arithmetic on sample data.

Reset
REQ-025 When reset=1 at a clock edge, x1_bit..x8_bit SHALL be 0, the state SHALL be IDLE, bit_cnt SHALL be 0, and frame_start and frame_done SHALL be 0.
REQ-026 Reset SHALL have priority over clear and accept; sample_ready SHALL be 0 while reset=1.
REQ-027 On reset mid-frame, the block SHALL abort the frame and issue no frame_done.

Verification
REQ-028 The bench SHALL check single load: after reset, sample_in=8'h01 with valid held for one cycle -> next cycle x1_bit=8'h01, other taps 0, frame_start=1, bit_slice=8'h01; bit_slice=0 for bit_cnt 1..7; frame_done at bit_cnt=7; IDLE after.
REQ-029 The bench SHALL check fill: load 01,02,04,...,80 back-to-back with valid held high -> frames every 8 cycles; after the 8th load x1..x8 = 80,40,20,10,08,04,02,01, and bit_slice = 8'h80 >> bit_cnt at bit_cnt 0..7, rotated so bit_slice[7-k]=1 at bit_cnt=k.
REQ-030 The bench SHALL check backpressure: valid high continuously -> sample_ready high only at IDLE or at bit_cnt=7; exactly one shift per 8 cycles; no sample lost or duplicated against a scoreboard.
REQ-031 The bench SHALL check clear versus valid: taps nonzero, clear=1 with valid=1 at bit_cnt=3 -> next cycle all taps 0, IDLE, no frame_done, sample not loaded.
REQ-032 The bench SHALL check reset mid-frame: reset pulsed at bit_cnt=5 -> all outputs at reset values the next cycle; a subsequent load of 8'h8F gives x1_bit=8'h8F and bit_slice[0] = 1,1,1,1,0,0,0,1 over bit_cnt 0..7.
